// File: rtl/rglib_rotate_pkg.sv
// Shared types and helpers for the rotate-unit input path.
// Default configuration: 32-bit data, 2-bit granules, 4-bit reduced shift.
package rglib_rotate_pkg;

   localparam int unsigned DefDataWidth      = 32;
   localparam int unsigned DefPowGranularity = 1;
   localparam int unsigned SHIFT_W           = $clog2(DefDataWidth >> DefPowGranularity);

   typedef struct packed {
      logic [DefDataWidth-1:0] data;
      logic [SHIFT_W-1:0]      shift;
   } rotate_cmd_t;

   // Keeps the low shift_w bits, i.e. the raw shift modulo the granule count.
   function automatic logic [31:0] shift_reduce(input logic [31:0] raw,
                                                input int unsigned shift_w);
      logic [31:0] mask;
      mask = (32'd1 << shift_w) - 32'd1;
      return raw & mask;
   endfunction

endpackage

// File: rtl/rglib_rotate_feed_mem.sv
// Command storage for rglib_rotate_feed: DEPTH entries, one write port, one
// asynchronous read port. Contents are intentionally not reset.
module rglib_rotate_feed_mem
   import rglib_rotate_pkg::*;
#(
   parameter type         cmd_t = rotate_cmd_t,
   parameter int unsigned DEPTH = 4
) (
   input  logic                     clk_i,
   input  logic                     we_i,
   input  logic [$clog2(DEPTH)-1:0] waddr_i,
   input  cmd_t                     wdata_i,
   input  logic [$clog2(DEPTH)-1:0] raddr_i,
   output cmd_t                     rdata_o
);

   cmd_t mem_q [DEPTH];

   always_ff @(posedge clk_i) begin
      if (we_i) begin
         mem_q[waddr_i] <= wdata_i;
      end
   end

   assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/rglib_rotate_feed.sv
// Circular command FIFO feeding the rotate unit; reduces shift modulo granule count.
// Optional zero-latency empty-FIFO bypass: RGLIB_ROTATE_FEED_BYPASS_EN.
module rglib_rotate_feed #(
   parameter int unsigned DATA_WIDTH      = 32,
   parameter int unsigned POW_GRANULARITY = 1,
   parameter int unsigned SHIFT_IN_W      = 8,
   parameter int unsigned DEPTH           = 4
) (
   input  logic                                             clk_i,
   input  logic                                             rst_i,
   input  logic [DATA_WIDTH-1:0]                            s_data_i,
   input  logic [SHIFT_IN_W-1:0]                            s_shift_i,
   input  logic                                             s_valid_i,
   output logic                                             s_ready_o,
   output logic [DATA_WIDTH-1:0]                            m_data_o,
   output logic [$clog2(DATA_WIDTH >> POW_GRANULARITY)-1:0] m_shift_o,
   output logic                                             m_valid_o,
   input  logic                                             m_ready_i,
   output logic [$clog2(DEPTH+1)-1:0]                       count_o
);

   import rglib_rotate_pkg::*;

   localparam int unsigned ShiftW = $clog2(DATA_WIDTH >> POW_GRANULARITY);
   localparam int unsigned PtrW   = $clog2(DEPTH);
   localparam int unsigned CntW   = $clog2(DEPTH + 1);

   typedef struct packed {
      logic [DATA_WIDTH-1:0] data;
      logic [ShiftW-1:0]     shift;
   } cmd_t;

   logic [PtrW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [CntW-1:0] count_q, count_d;
   cmd_t            wr_cmd, rd_cmd;
   logic            empty, full, bypass, push, pop;

   assign wr_cmd.data  = s_data_i;
   assign wr_cmd.shift = ShiftW'(shift_reduce(32'(s_shift_i), ShiftW));

   assign empty = (count_q == '0);
   assign full  = (count_q == CntW'(DEPTH));

`ifdef RGLIB_ROTATE_FEED_BYPASS_EN
   assign bypass = empty & s_valid_i;
`else
   assign bypass = 1'b0;
`endif

   assign s_ready_o = ~full;
   assign m_valid_o = ~empty | bypass;
   assign count_o   = count_q;

   // A bypassed command taken by the rotate unit never touches storage.
   assign push = s_valid_i & ~full & ~(bypass & m_ready_i);
   assign pop  = ~empty & m_ready_i;

   // Outputs read zero when nothing is presented, so stale storage never leaks out.
   always_comb begin
      m_data_o  = '0;
      m_shift_o = '0;
      if (!empty) begin
         m_data_o  = rd_cmd.data;
         m_shift_o = rd_cmd.shift;
      end else if (bypass) begin
         m_data_o  = wr_cmd.data;
         m_shift_o = wr_cmd.shift;
      end
   end

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (push) begin
         wr_ptr_d = wr_ptr_q + PtrW'(1);
      end
      if (pop) begin
         rd_ptr_d = rd_ptr_q + PtrW'(1);
      end
      case ({push, pop})
         2'b10:   count_d = count_q + CntW'(1);
         2'b01:   count_d = count_q - CntW'(1);
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   rglib_rotate_feed_mem #(
      .cmd_t (cmd_t),
      .DEPTH (DEPTH)
   ) u_mem (
      .clk_i   (clk_i),
      .we_i    (push),
      .waddr_i (wr_ptr_q),
      .wdata_i (wr_cmd),
      .raddr_i (rd_ptr_q),
      .rdata_o (rd_cmd)
   );

endmodule
